// File: rtl/msu_audio_pkg.sv
// Shared widths, constants and the volume-to-gain mapping for the MSU-1 audio volume stage.
package msu_audio_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int VOL_W        = 8;
    localparam int GAIN_W       = 9;
    localparam int ROUND_BIAS   = 128;
    localparam int GAIN_SHIFT   = 8;
    localparam int RAMP_CNT_W   = 16;

    typedef enum logic {
        RAMP_IDLE = 1'b0,
        RAMP_RUN  = 1'b1
    } ramp_state_e;

    // 0xff maps to 256 so full volume is an exact pass-through.
    function automatic logic [GAIN_W-1:0] gain_from_vol(input logic [VOL_W-1:0] vol);
        gain_from_vol = {1'b0, vol} + {{(GAIN_W-1){1'b0}}, (vol == 8'hff)};
    endfunction

endpackage

// File: rtl/msu_vol_mul.sv
// One channel of the volume pipeline: signed multiply in S1, round and shift in S2.
module msu_vol_mul
    import msu_audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                s1_load_i,
    input  logic                s2_load_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [GAIN_W-1:0]   gain_i,
    output logic [SAMPLE_W-1:0] result_o
);

    localparam int PROD_W = SAMPLE_W + GAIN_W;

    logic signed [PROD_W-1:0] samp_ext_s;
    logic signed [PROD_W-1:0] gain_ext_s;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic [SAMPLE_W-1:0]      res_d;
    logic [SAMPLE_W-1:0]      res_q;

    // Product and rounded result; the shifted value always fits SAMPLE_W.
    always_comb begin
        samp_ext_s = PROD_W'($signed(sample_i));
        gain_ext_s = PROD_W'(gain_i);
        prod_d     = samp_ext_s * gain_ext_s;
        res_d      = SAMPLE_W'((prod_q + PROD_W'(ROUND_BIAS)) >>> GAIN_SHIFT);
    end

    // Stage registers, each advanced by its own enable from the shared handshake.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            if (s1_load_i) begin
                prod_q <= prod_d;
            end
            if (s2_load_i) begin
                res_q <= res_d;
            end
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/msu_audio_vol.sv
// Applies the MSU-1 volume to the stereo PCM stream, ramping the gain one LSB per RAMP_FRAMES frames.
module msu_audio_vol
    import msu_audio_pkg::*;
#(
    parameter int         SAMPLE_W    = SAMPLE_W_DEF,
    parameter int         RAMP_FRAMES = 4,
    parameter logic [7:0] VOL_INIT    = 8'hff
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic [VOL_W-1:0]    volume_in,
    input  logic                volume_latch,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic [VOL_W-1:0]    vol_current,
    output logic                ramp_busy
);

    localparam logic [RAMP_CNT_W-1:0] CNT_LAST = RAMP_CNT_W'(RAMP_FRAMES - 1);

    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  latch_q;
    logic [VOL_W-1:0]      cur_q, cur_d;
    logic [VOL_W-1:0]      tgt_q, tgt_d;
    logic [RAMP_CNT_W-1:0] cnt_q, cnt_d;
    ramp_state_e           state_q, state_d;

    logic                  stall_s2_s;
    logic                  stall_s1_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  s2_load_s;
    logic [GAIN_W-1:0]     gain_s;

    // Handshake: S2 blocked by the sink; S1 blocked only if S2 cannot drain, so bubbles collapse.
    always_comb begin
        stall_s2_s = s2_valid_q & ~out_ready;
        stall_s1_s = s1_valid_q & stall_s2_s;
        in_ready_s = ~s1_valid_q | ~stall_s2_s;
        accept_s   = in_valid & in_ready_s;
        s2_load_s  = s1_valid_q & ~stall_s2_s;
        gain_s     = gain_from_vol(cur_q);
        s1_valid_d = stall_s1_s ? s1_valid_q : in_valid;
        s2_valid_d = stall_s2_s ? 1'b1 : s1_valid_q;
    end

    // Target capture and the frame-paced ramp FSM.
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        cnt_d = cnt_q;
        if (volume_latch && !latch_q) begin
            tgt_d = volume_in;
        end else begin
            tgt_d = tgt_q;
        end
        case (state_q)
            RAMP_IDLE: begin
                cnt_d = '0;
            end
            RAMP_RUN: begin
                if (accept_s) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (cur_q < tgt_q) begin
                            cur_d = cur_q + 8'd1;
                        end else begin
                            cur_d = cur_q - 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        state_d = (cur_d != tgt_d) ? RAMP_RUN : RAMP_IDLE;
    end

    // Pipeline valids, latch edge register and ramp state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            latch_q    <= 1'b0;
            cur_q      <= VOL_INIT;
            tgt_q      <= VOL_INIT;
            cnt_q      <= '0;
            state_q    <= RAMP_IDLE;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            latch_q    <= volume_latch;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    msu_vol_mul #(.SAMPLE_W(SAMPLE_W)) u_mul_left (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .s1_load_i (accept_s),
        .s2_load_i (s2_load_s),
        .sample_i  (in_left),
        .gain_i    (gain_s),
        .result_o  (out_left)
    );

    msu_vol_mul #(.SAMPLE_W(SAMPLE_W)) u_mul_right (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .s1_load_i (accept_s),
        .s2_load_i (s2_load_s),
        .sample_i  (in_right),
        .gain_i    (gain_s),
        .result_o  (out_right)
    );

    assign in_ready    = in_ready_s;
    assign out_valid   = s2_valid_q;
    assign vol_current = cur_q;
    assign ramp_busy   = (state_q == RAMP_RUN);

endmodule

// File: tb/tb_msu_audio_vol.sv
// Directed, table-driven bench for msu_audio_vol with RAMP_FRAMES = 4.
module tb_msu_audio_vol;

    logic        clkin = 1'b0;
    logic        rst_n;
    logic [7:0]  volume_in;
    logic        volume_latch;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic [7:0]  vol_current;
    logic        ramp_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] el;
        logic [15:0] er;
        logic [7:0]  vol;
    } vec_t;

    vec_t vecs[13];

    always #5 clkin = ~clkin;

    msu_audio_vol #(.SAMPLE_W(16), .RAMP_FRAMES(4), .VOL_INIT(8'hff)) dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .volume_in    (volume_in),
        .volume_latch (volume_latch),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_left     (out_left),
        .out_right    (out_right),
        .vol_current  (vol_current),
        .ramp_busy    (ramp_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                             output logic [15:0] ol, output logic [15:0] orr, output int lat);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        check("frame_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clkin);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 6) begin
            @(negedge clkin);
            lat++;
        end
        ol  = out_left;
        orr = out_right;
        @(negedge clkin);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        logic [15:0] ol, orr;
        int lat;
        for (int i = lo; i <= hi; i++) begin
            check("vec_vol", {24'd0, vol_current}, {24'd0, vecs[i].vol});
            run_frame(vecs[i].l, vecs[i].r, ol, orr, lat);
            check("vec_latency", lat, 32'd2);
            check("vec_left", {16'd0, ol}, {16'd0, vecs[i].el});
            check("vec_right", {16'd0, orr}, {16'd0, vecs[i].er});
        end
    endtask

    task automatic stream(input int n);
        int acc = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_left  = 16'h1000;
        in_right = 16'hF000;
        while (acc < n && guard < 4 * n + 20) begin
            if (in_ready) acc++;
            @(negedge clkin);
            guard++;
        end
        in_valid = 1'b0;
        check("stream_accepts", acc, n);
        repeat (3) @(negedge clkin);
    endtask

    task automatic latch(input logic [7:0] v);
        volume_in    = v;
        volume_latch = 1'b1;
        @(negedge clkin);
        volume_latch = 1'b0;
        @(negedge clkin);
    endtask

    task automatic check_vol(input string name, input logic [7:0] v, input logic busy);
        check(name, {24'd0, vol_current}, {24'd0, v});
        check({name, "_busy"}, {31'd0, ramp_busy}, {31'd0, busy});
    endtask

    initial begin
        logic [15:0] gl[2];
        logic [15:0] gr[2];
        int acc;
        int got;

        vecs[0]  = '{16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 8'hff};
        vecs[1]  = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 8'hff};
        vecs[2]  = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 8'hff};
        vecs[3]  = '{16'h0000, 16'h5A5A, 16'h0000, 16'h5A5A, 8'hff};
        vecs[4]  = '{16'h1000, 16'hF000, 16'h0800, 16'hF800, 8'h80};
        vecs[5]  = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 8'h80};
        vecs[6]  = '{16'h7FFF, 16'h8000, 16'h4000, 16'hC000, 8'h80};
        vecs[7]  = '{16'h0003, 16'hFFFD, 16'h0002, 16'hFFFF, 8'h80};
        vecs[8]  = '{16'h00FF, 16'hFF01, 16'h0080, 16'hFF81, 8'h80};
        vecs[9]  = '{16'h0002, 16'hFFFE, 16'h0001, 16'hFFFF, 8'h80};
        vecs[10] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 8'h00};
        vecs[11] = '{16'h1234, 16'hEDCC, 16'h0000, 16'h0000, 8'h00};
        vecs[12] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 8'h00};

        rst_n        = 1'b0;
        volume_in    = 8'h00;
        volume_latch = 1'b0;
        in_valid     = 1'b0;
        in_left      = 16'h0000;
        in_right     = 16'h0000;
        out_ready    = 1'b1;
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_left", {16'd0, out_left}, 32'd0);
        check("rst_out_right", {16'd0, out_right}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_vol("rst_vol", 8'hff, 1'b0);

        apply_vecs(0, 3);

        latch(8'h80);
        check_vol("latch80", 8'hff, 1'b1);
        stream(3);
        check_vol("ramp_3", 8'hff, 1'b1);
        stream(1);
        check_vol("ramp_4", 8'hfe, 1'b1);
        stream(503);
        check_vol("ramp_507", 8'h81, 1'b1);
        stream(1);
        check_vol("ramp_508", 8'h80, 1'b0);
        apply_vecs(4, 9);

        latch(8'hff);
        stream(508);
        check_vol("up_ff", 8'hff, 1'b0);

        latch(8'h00);
        stream(1019);
        check_vol("down_1019", 8'h01, 1'b1);
        stream(1);
        check_vol("down_1020", 8'h00, 1'b0);
        apply_vecs(10, 12);

        latch(8'hff);
        stream(1020);
        check_vol("up_1020", 8'hff, 1'b0);

        latch(8'h00);
        stream(252);
        check_vol("mid_c0", 8'hc0, 1'b1);
        latch(8'hf0);
        check_vol("reverse_nojump", 8'hc0, 1'b1);
        stream(191);
        check_vol("reverse_191", 8'hef, 1'b1);
        stream(1);
        check_vol("reverse_192", 8'hf0, 1'b0);

        latch(8'hf0);
        check_vol("same_latch", 8'hf0, 1'b0);
        stream(8);
        check_vol("same_latch_frames", 8'hf0, 1'b0);

        latch(8'hff);
        stream(60);
        check_vol("back_ff", 8'hff, 1'b0);

        // Backpressure: sink blocked for 10 cycles with a continuous source.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_left  = 16'h0100 + 16'(acc);
            in_right = 16'hA000 + 16'(acc);
            if (in_ready) acc++;
            @(negedge clkin);
        end
        check("bp_accepts", acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_left", {16'd0, out_left}, 32'h0100);
        check("bp_hold_right", {16'd0, out_right}, 32'hA000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        gl[0] = '0; gl[1] = '0; gr[0] = '0; gr[1] = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                if (got < 2) begin
                    gl[got] = out_left;
                    gr[got] = out_right;
                end
                got++;
            end
            @(negedge clkin);
        end
        check("bp_drain_count", got, 32'd2);
        check("bp_first_left", {16'd0, gl[0]}, 32'h0100);
        check("bp_second_left", {16'd0, gl[1]}, 32'h0101);
        check("bp_second_right", {16'd0, gr[1]}, 32'hA001);

        // Reset with both stages full, mid-ramp.
        latch(8'h00);
        stream(6);
        check_vol("pre_rst", 8'hfe, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_left   = 16'h2222;
        in_right  = 16'h3333;
        repeat (3) @(negedge clkin);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clkin);
        rst_n = 1'b1;
        @(negedge clkin);
        check_vol("post_rst", 8'hff, 1'b0);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        apply_vecs(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
